// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers a K-vector tile and streams it to the array edge, lane i delayed i cycles.
// Optional FEEDER_DBUF_EN: second ping-pong bank that loads while the other bank streams.

module systolic_feeder_lane #(
  parameter int K    = 4,
  parameter int TW   = 3,
  parameter int LANE = 0
) (
  input  logic              i_en,
  input  logic [TW-1:0]     i_t,
  input  logic [K-1:0][7:0] i_col,
  output logic [7:0]        o_data,
  output logic              o_fire
);
  // Lane LANE shows row k on stream cycle k+LANE.
  always_comb begin
    o_data = '0;
    o_fire = 1'b0;
    for (int k = 0; k < K; k++)
      if (i_en && i_t == TW'(k + LANE)) begin
        o_data = i_col[k];
        o_fire = 1'b1;
      end
  end
endmodule

module systolic_feeder #(
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [8*N-1:0] in_vec,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [8*N-1:0] out_data,
  output logic [N-1:0]   out_fire,
  output logic           tile_done,
  output logic           busy
);
`ifdef FEEDER_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif
  localparam int TW = $clog2(K + N);
  localparam int CW = $clog2(K + 1);
  localparam logic [TW-1:0] T_LAST = TW'(K + N - 2);

  typedef enum logic [1:0] {S_LOAD, S_STREAM, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [1:0][K-1:0][8*N-1:0] r_buf, w_buf_nxt;
  logic [1:0][CW-1:0]         r_ld_cnt;
  logic                       r_lbank, r_sbank, w_sbank_nxt;
  logic [TW-1:0]              r_t, w_t_nxt;
  logic [CW-1:0]              w_lcnt;
  logic                       w_acc, w_full_nxt, w_go;
  logic [N-1:0][K-1:0][7:0]   w_col;
  logic [N-1:0][7:0]          w_lane_data;
  logic [N-1:0]               w_lane_fire;
  logic [8*N-1:0]             r_out_data;
  logic [N-1:0]               r_out_fire;
  logic                       r_tile_done;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_LOAD;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:   if (w_go) w_state_nxt = S_STREAM;
      S_STREAM: if (r_t == T_LAST) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = w_go ? S_STREAM : S_LOAD;
      default:  w_state_nxt = S_LOAD;
    endcase
  end

  // w_go: the load bank is full after this cycle and the stream slot is free.
  always_comb begin
    w_lcnt     = r_ld_cnt[r_lbank];
    in_ready   = ~rst && (w_lcnt < CW'(K)) && (r_state == S_LOAD || DBUF);
    w_acc      = in_valid && in_ready;
    w_full_nxt = (w_lcnt + CW'(w_acc)) == CW'(K);
    w_go       = w_full_nxt && (r_state == S_LOAD || (DBUF && r_state == S_DONE));
    busy       = (r_state != S_LOAD);
  end

  // Lanes read the post-write buffer so a just-accepted row is visible on stream cycle 0.
  always_comb begin
    w_buf_nxt = r_buf;
    for (int k = 0; k < K; k++)
      if (w_acc && w_lcnt == CW'(k)) w_buf_nxt[r_lbank][k] = in_vec;
    w_sbank_nxt = w_go ? r_lbank : r_sbank;
    w_t_nxt     = (r_state == S_STREAM) ? r_t + TW'(1) : '0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K; k++)
        w_col[i][k] = w_buf_nxt[w_sbank_nxt][k][8*i +: 8];
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    systolic_feeder_lane #(.K(K), .TW(TW), .LANE(g)) u_lane (
      .i_en   (w_state_nxt == S_STREAM),
      .i_t    (w_t_nxt),
      .i_col  (w_col[g]),
      .o_data (w_lane_data[g]),
      .o_fire (w_lane_fire[g])
    );
  end

  always_ff @(posedge clk) r_buf <= w_buf_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_t         <= '0;
      r_ld_cnt    <= '0;
      r_lbank     <= 1'b0;
      r_sbank     <= 1'b0;
      r_out_data  <= '0;
      r_out_fire  <= '0;
      r_tile_done <= 1'b0;
    end else begin
      r_t     <= w_t_nxt;
      r_sbank <= w_sbank_nxt;
      if (w_go) begin
        r_ld_cnt[r_lbank] <= '0;
        r_lbank           <= DBUF ? ~r_lbank : r_lbank;
      end else if (w_acc) begin
        r_ld_cnt[r_lbank] <= w_lcnt + CW'(1);
      end
      r_out_data  <= w_lane_data;
      r_out_fire  <= w_lane_fire;
      r_tile_done <= (w_state_nxt == S_DONE);
    end
  end

  assign out_data  = r_out_data;
  assign out_fire  = r_out_fire;
  assign tile_done = r_tile_done;
endmodule
